pe_matmul_sequencer: RTL and testbench

//  Upstream control stage for the processing element. Walks C = A x B over row-major matrices in shared RAM.
//  Per output element it drives K consecutive left/right operand addresses, then asserts vec_fin with result_addr.
//  The PE accumulates the products and writes C[i][j]. Handshake to the host is start/busy/done.

---
 rtl/pe_matmul_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_pe_matmul_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_matmul_sequencer.sv
// Address sequencer for a processing element computing C = A x B over row-major matrices.
// Emits k operand address pairs per output element, flags the last one with vec_fin, then pulses done.
module pe_matmul_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  m,
  input  logic [DIM_W-1:0]  k,
  input  logic [DIM_W-1:0]  n,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  input  logic              step_fin,
  output logic              active,
  output logic              vec_fin,
  output logic [ADDR_W-1:0] left_addr,
  output logic [ADDR_W-1:0] right_addr,
  output logic [ADDR_W-1:0] result_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DIM_W-1:0]  DIM_ZERO = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0]  DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [DIM_W-1:0]   m_last_r, m_last_s, k_last_r, k_last_s, n_last_r, n_last_s;
  logic [DIM_W-1:0]   i_r, i_s, j_r, j_s, p_r, p_s;
  logic [ADDR_W-1:0]  k_ext_r, k_ext_s, n_ext_r, n_ext_s;
  logic [ADDR_W-1:0]  row_a_r, row_a_s, b_base_r, b_base_s, col_b_r, col_b_s;
  logic [ADDR_W-1:0]  left_r, left_s, right_r, right_s, result_r, result_s;
  logic               active_r, active_s, vec_fin_r, vec_fin_s, busy_r, busy_s, done_r, done_s;

  // Incremental address steps; row_a_r tracks a_base + i*k, col_b_r tracks b_base + j.
  logic [DIM_W-1:0]   p_inc_s;
  logic [ADDR_W-1:0]  left_inc_s, right_step_s, col_next_s, row_next_s, result_inc_s;

  assign p_inc_s      = p_r + DIM_ONE;
  assign left_inc_s   = left_r + ADDR_ONE;
  assign right_step_s = right_r + n_ext_r;
  assign col_next_s   = col_b_r + ADDR_ONE;
  assign row_next_s   = row_a_r + k_ext_r;
  assign result_inc_s = result_r + ADDR_ONE;

  assign active      = active_r;
  assign vec_fin     = vec_fin_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign left_addr   = left_r;
  assign right_addr  = right_r;
  assign result_addr = result_r;

  // Next-state and next-output logic for the walk over (i, j, p).
  always_comb begin
    state_s   = state_r;
    m_last_s  = m_last_r;
    k_last_s  = k_last_r;
    n_last_s  = n_last_r;
    i_s       = i_r;
    j_s       = j_r;
    p_s       = p_r;
    k_ext_s   = k_ext_r;
    n_ext_s   = n_ext_r;
    row_a_s   = row_a_r;
    b_base_s  = b_base_r;
    col_b_s   = col_b_r;
    left_s    = left_r;
    right_s   = right_r;
    result_s  = result_r;
    active_s  = active_r;
    vec_fin_s = vec_fin_r;
    busy_s    = busy_r;
    done_s    = done_r;
    case (state_r)
      ST_IDLE: begin
        done_s = 1'b0;
        if (start) begin
          m_last_s = m - DIM_ONE;
          k_last_s = k - DIM_ONE;
          n_last_s = n - DIM_ONE;
          k_ext_s  = {{(ADDR_W-DIM_W){1'b0}}, k};
          n_ext_s  = {{(ADDR_W-DIM_W){1'b0}}, n};
          i_s      = DIM_ZERO;
          j_s      = DIM_ZERO;
          p_s      = DIM_ZERO;
          row_a_s  = a_base;
          b_base_s = b_base;
          col_b_s  = b_base;
          left_s   = a_base;
          right_s  = b_base;
          result_s = c_base;
          if ((m == DIM_ZERO) || (k == DIM_ZERO) || (n == DIM_ZERO)) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            state_s   = ST_RUN;
            active_s  = 1'b1;
            busy_s    = 1'b1;
            vec_fin_s = (k == DIM_ONE);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (step_fin) begin
          if (p_r != k_last_r) begin
            p_s       = p_inc_s;
            left_s    = left_inc_s;
            right_s   = right_step_s;
            vec_fin_s = (p_inc_s == k_last_r);
          end else if (j_r != n_last_r) begin
            p_s       = DIM_ZERO;
            j_s       = j_r + DIM_ONE;
            col_b_s   = col_next_s;
            left_s    = row_a_r;
            right_s   = col_next_s;
            result_s  = result_inc_s;
            vec_fin_s = (k_last_r == DIM_ZERO);
          end else if (i_r != m_last_r) begin
            p_s       = DIM_ZERO;
            j_s       = DIM_ZERO;
            i_s       = i_r + DIM_ONE;
            row_a_s   = row_next_s;
            col_b_s   = b_base_r;
            left_s    = row_next_s;
            right_s   = b_base_r;
            result_s  = result_inc_s;
            vec_fin_s = (k_last_r == DIM_ZERO);
          end else begin
            state_s   = ST_DONE;
            active_s  = 1'b0;
            busy_s    = 1'b0;
            vec_fin_s = 1'b0;
            done_s    = 1'b1;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        done_s  = 1'b0;
      end
      default: begin
        state_s   = ST_IDLE;
        active_s  = 1'b0;
        busy_s    = 1'b0;
        vec_fin_s = 1'b0;
        done_s    = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      m_last_r  <= {DIM_W{1'b0}};
      k_last_r  <= {DIM_W{1'b0}};
      n_last_r  <= {DIM_W{1'b0}};
      i_r       <= {DIM_W{1'b0}};
      j_r       <= {DIM_W{1'b0}};
      p_r       <= {DIM_W{1'b0}};
      k_ext_r   <= {ADDR_W{1'b0}};
      n_ext_r   <= {ADDR_W{1'b0}};
      row_a_r   <= {ADDR_W{1'b0}};
      b_base_r  <= {ADDR_W{1'b0}};
      col_b_r   <= {ADDR_W{1'b0}};
      left_r    <= {ADDR_W{1'b0}};
      right_r   <= {ADDR_W{1'b0}};
      result_r  <= {ADDR_W{1'b0}};
      active_r  <= 1'b0;
      vec_fin_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      m_last_r  <= m_last_s;
      k_last_r  <= k_last_s;
      n_last_r  <= n_last_s;
      i_r       <= i_s;
      j_r       <= j_s;
      p_r       <= p_s;
      k_ext_r   <= k_ext_s;
      n_ext_r   <= n_ext_s;
      row_a_r   <= row_a_s;
      b_base_r  <= b_base_s;
      col_b_r   <= col_b_s;
      left_r    <= left_s;
      right_r   <= right_s;
      result_r  <= result_s;
      active_r  <= active_s;
      vec_fin_r <= vec_fin_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

endmodule

// File: tb/tb_pe_matmul_sequencer.sv
// Bench for pe_matmul_sequencer: a queue-based model of the (i, j, p) walk checked every cycle,
// plus literal address/timing expectations for the directed jobs.
module tb_pe_matmul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, step_fin;
  logic [7:0]  m, k, n;
  logic [31:0] a_base, b_base, c_base;
  logic        active, vec_fin, busy, done;
  logic [31:0] left_addr, right_addr, result_addr;

  pe_matmul_sequencer #(.ADDR_W(32), .DIM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m(m), .k(k), .n(n),
    .a_base(a_base), .b_base(b_base), .c_base(c_base), .step_fin(step_fin),
    .active(active), .vec_fin(vec_fin), .left_addr(left_addr), .right_addr(right_addr),
    .result_addr(result_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] res;
    logic        v;
  } step_t;

  localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;

  step_t       exp_q[$];
  int          phase = P_IDLE;
  logic        exp_done = 1'b0;
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, c0 = 0, done_rel = -1;
  logic [31:0] cap_l[$], cap_r[$], cap_res[$];
  int          vf_rel[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: expected per-step addresses are built from the closed-form index formulas.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      phase    = P_IDLE;
      exp_done = 1'b0;
    end else begin
      case (phase)
        P_IDLE: begin
          exp_done = 1'b0;
          if (start) begin
            for (int i = 0; i < int'(m); i++)
              for (int j = 0; j < int'(n); j++)
                for (int p = 0; p < int'(k); p++) begin
                  step_t s;
                  s.l   = a_base + 32'(i * int'(k) + p);
                  s.r   = b_base + 32'(p * int'(n) + j);
                  s.res = c_base + 32'(i * int'(n) + j);
                  s.v   = (p == int'(k) - 1);
                  exp_q.push_back(s);
                end
            if (exp_q.size() == 0) begin
              phase    = P_DONE;
              exp_done = 1'b1;
            end else begin
              phase = P_RUN;
            end
          end
        end
        P_RUN: begin
          if (step_fin) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
              phase    = P_DONE;
              exp_done = 1'b1;
            end
          end
        end
        default: begin
          phase    = P_IDLE;
          exp_done = 1'b0;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge; also captures traces.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_vec_fin", 32'(vec_fin), 32'd0);
      chk("rst_left", left_addr, 32'd0);
      chk("rst_right", right_addr, 32'd0);
      chk("rst_result", result_addr, 32'd0);
    end else begin
      chk("active", 32'(active), 32'(phase == P_RUN));
      chk("busy", 32'(busy), 32'(phase == P_RUN));
      chk("done", 32'(done), 32'(exp_done));
      if (phase == P_RUN && exp_q.size() > 0) begin
        chk("left_addr", left_addr, exp_q[0].l);
        chk("right_addr", right_addr, exp_q[0].r);
        chk("result_addr", result_addr, exp_q[0].res);
        chk("vec_fin", 32'(vec_fin), 32'(exp_q[0].v));
      end else begin
        chk("vec_fin_off", 32'(vec_fin), 32'd0);
      end
      if (active) begin
        cap_l.push_back(left_addr);
        cap_r.push_back(right_addr);
        cap_res.push_back(result_addr);
      end
      if (vec_fin) vf_rel.push_back(cyc - c0);
      if (done) done_rel = cyc - c0;
    end
  end

  task automatic run_job(input logic [7:0] mm, input logic [7:0] kk, input logic [7:0] nn,
                         input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] cc,
                         input int stall_rel, input int stall_len, input int restart_rel,
                         input int reset_rel);
    int rel;
    m = mm; k = kk; n = nn; a_base = aa; b_base = bb; c_base = cc;
    cap_l.delete(); cap_r.delete(); cap_res.delete(); vf_rel.delete();
    done_rel = -1;
    @(posedge clk); #2;
    start = 1'b1;
    c0 = cyc;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #2;
      rel = cyc - c0;
      if (done_rel >= 0) break;
      start    = (rel == restart_rel);
      step_fin = (rel >= stall_rel && rel < stall_rel + stall_len) ? 1'b0 : 1'b1;
      if (rel == reset_rel) begin
        rst_n = 1'b0;
        #1;
        chk("async_active", 32'(active), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_vec_fin", 32'(vec_fin), 32'd0);
        chk("async_left", left_addr, 32'd0);
        chk("async_right", right_addr, 32'd0);
        chk("async_result", result_addr, 32'd0);
        @(posedge clk); #2;
        rst_n    = 1'b1;
        start    = 1'b0;
        step_fin = 1'b1;
        return;
      end
    end
    start    = 1'b0;
    step_fin = 1'b1;
    if (done_rel < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_case1(input string tag);
    int el[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int er[8] = '{4, 6, 5, 7, 4, 6, 5, 7};
    int ev[4] = '{2, 4, 6, 8};
    chk({tag, "_n_active"}, 32'(cap_l.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < cap_l.size()) begin
        chk({tag, "_left"}, cap_l[i], 32'(el[i]));
        chk({tag, "_right"}, cap_r[i], 32'(er[i]));
      end
    end
    chk({tag, "_n_vec_fin"}, 32'(vf_rel.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < vf_rel.size()) chk({tag, "_vec_fin_cycle"}, 32'(vf_rel[i]), 32'(ev[i]));
      if (2 * i + 1 < cap_res.size()) chk({tag, "_result"}, cap_res[2 * i + 1], 32'(8 + i));
    end
    chk({tag, "_done_cycle"}, 32'(done_rel), 32'd9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; step_fin = 1'b1;
    m = 8'd0; k = 8'd0; n = 8'd0;
    a_base = 32'd0; b_base = 32'd0; c_base = 32'd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // 2x2x2 basic walk
    run_job(8'd2, 8'd2, 8'd2, 32'd0, 32'd4, 32'd8, -1, 0, -1, -1);
    check_case1("c1");

    // single element
    run_job(8'd1, 8'd1, 8'd1, 32'd5, 32'd6, 32'd7, -1, 0, -1, -1);
    chk("c2_n_active", 32'(cap_l.size()), 32'd1);
    if (cap_l.size() > 0) begin
      chk("c2_left", cap_l[0], 32'd5);
      chk("c2_right", cap_r[0], 32'd6);
      chk("c2_result", cap_res[0], 32'd7);
    end
    chk("c2_n_vec_fin", 32'(vf_rel.size()), 32'd1);
    chk("c2_done_cycle", 32'(done_rel), 32'd2);

    // empty dot product
    run_job(8'd3, 8'd0, 8'd3, 32'd10, 32'd20, 32'd30, -1, 0, -1, -1);
    chk("c3_n_active", 32'(cap_l.size()), 32'd0);
    chk("c3_done_cycle", 32'(done_rel), 32'd1);

    // stall 3 cycles on p=1 of element (0,0)
    run_job(8'd2, 8'd2, 8'd2, 32'd0, 32'd4, 32'd8, 2, 3, -1, -1);
    chk("c4_n_active", 32'(cap_l.size()), 32'd11);
    chk("c4_n_vec_fin", 32'(vf_rel.size()), 32'd7);
    if (cap_l.size() > 4) begin
      chk("c4_left_held", cap_l[4], 32'd1);
      chk("c4_right_held", cap_r[4], 32'd6);
    end
    chk("c4_done_cycle", 32'(done_rel), 32'd12);

    // start pulse while running is ignored
    run_job(8'd2, 8'd2, 8'd2, 32'd0, 32'd4, 32'd8, -1, 0, 3, -1);
    check_case1("c5");

    // reset mid-run, then a fresh job
    run_job(8'd2, 8'd2, 8'd2, 32'd0, 32'd4, 32'd8, -1, 0, -1, 3);
    repeat (2) @(posedge clk);
    #2;
    run_job(8'd2, 8'd2, 8'd2, 32'd0, 32'd4, 32'd8, -1, 0, -1, -1);
    check_case1("c6");

    // left address wraps
    run_job(8'd1, 8'd2, 8'd1, 32'hFFFF_FFFF, 32'h100, 32'h200, -1, 0, -1, -1);
    chk("c7_n_active", 32'(cap_l.size()), 32'd2);
    if (cap_l.size() > 1) begin
      chk("c7_left0", cap_l[0], 32'hFFFF_FFFF);
      chk("c7_left1", cap_l[1], 32'h0000_0000);
      chk("c7_right1", cap_r[1], 32'h0000_0101);
    end
    chk("c7_done_cycle", 32'(done_rel), 32'd3);

    // rectangular job with a short stall
    run_job(8'd3, 8'd4, 8'd2, 32'h1000, 32'h2000, 32'h3000, 5, 2, -1, -1);
    chk("c8_n_active", 32'(cap_l.size()), 32'd26);
    chk("c8_done_cycle", 32'(done_rel), 32'd27);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
